// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus fabric: slave map access, latency type,
// status block offsets and FSM state encoding.
package cpu_bus_pkg;

  localparam int unsigned MaxAddrWidth = 32;
  localparam int unsigned MaxSlaves    = 32;
  localparam int unsigned MapWidth     = 2 * MaxAddrWidth * MaxSlaves;

  typedef logic [MaxAddrWidth-1:0]   addr_t;
  typedef logic [2*MaxAddrWidth-1:0] range_t;
  typedef logic [MapWidth-1:0]       map_t;
  typedef logic [1:0]                latency_t;

  localparam logic [1:0] StatusFlags  = 2'd0;
  localparam logic [1:0] StatusAddrLo = 2'd1;
  localparam logic [1:0] StatusAddrHi = 2'd2;
  localparam logic [1:0] StatusCount  = 2'd3;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {ACC_SLAVE, ACC_STATUS, ACC_NONE} access_t;

  function automatic addr_t addr_mask(input int unsigned aw);
    range_t one_hot;
    if (aw >= MaxAddrWidth) return '1;
    one_hot = range_t'(1) << aw;
    return addr_t'(one_hot - range_t'(1));
  endfunction

  // Builds one {start,end} map entry for an aw-bit address space.
  function automatic range_t add_address(input addr_t start_addr, input addr_t end_addr,
                                         input int unsigned aw);
    return (range_t'(start_addr & addr_mask(aw)) << aw) | range_t'(end_addr & addr_mask(aw));
  endfunction

  function automatic addr_t get_address_end(input map_t map, input int unsigned num,
                                            input int unsigned aw, input int unsigned idx);
    map_t sh;
    sh = map >> ((num - 1 - idx) * 2 * aw);
    return addr_t'(sh) & addr_mask(aw);
  endfunction

  function automatic addr_t get_address_start(input map_t map, input int unsigned num,
                                              input int unsigned aw, input int unsigned idx);
    map_t sh;
    sh = map >> ((num - 1 - idx) * 2 * aw + aw);
    return addr_t'(sh) & addr_mask(aw);
  endfunction

endpackage

// File: rtl/cpu_bus_fabric_decoder.sv
// Combinational priority range decoder: inclusive start/end compare per slave,
// lowest matching index wins.
module cpu_bus_decoder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned address_width = 16,
  parameter int unsigned NumSlaves     = 12,
  parameter int unsigned IdxWidth      = (NumSlaves > 1) ? $clog2(NumSlaves) : 1,
  parameter logic [2*address_width*NumSlaves-1:0] SlaveMap = '0
) (
  input  logic [address_width-1:0] address_i,
  output logic [NumSlaves-1:0]     sel_o,
  output logic                     hit_o,
  output logic [IdxWidth-1:0]      idx_o
);

  logic [address_width-1:0] start_tab [NumSlaves];
  logic [address_width-1:0] end_tab   [NumSlaves];

  for (genvar g = 0; g < NumSlaves; g++) begin : g_range
    assign start_tab[g] = address_width'(get_address_start(map_t'(SlaveMap), NumSlaves,
                                                           address_width, g));
    assign end_tab[g]   = address_width'(get_address_end(map_t'(SlaveMap), NumSlaves,
                                                         address_width, g));
  end

  // Scan from the highest index down so the lowest matching slave is the last to assign.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned i = NumSlaves; i > 0; i--) begin
      if (address_i >= start_tab[i-1] && address_i <= end_tab[i-1]) begin
        sel_o        = '0;
        sel_o[i-1]   = 1'b1;
        hit_o        = 1'b1;
        idx_o        = IdxWidth'(i - 1);
      end
    end
  end

endmodule

// File: rtl/cpu_bus_fabric.sv
// CPU bus interconnect: address decode, read-data mux with per-slave wait states,
// and a 4-byte status block that records unmapped accesses.
module cpu_bus_fabric
  import cpu_bus_pkg::*;
#(
  parameter int unsigned address_width = 16,
  parameter int unsigned data_width    = 8,
  parameter int unsigned NumSlaves     = 12,
  parameter logic [2*address_width*NumSlaves-1:0] SlaveMap     = '0,
  parameter logic [2*NumSlaves-1:0]               SlaveLatency = '0,
  parameter logic [address_width-1:0] StatusBaseAddress = 'h9FF0,
  parameter logic [data_width-1:0]    DefaultData       = 'hEA
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [address_width-1:0]        address_i,
  input  logic [data_width-1:0]           data_i,
  input  logic                            rd_wr_i,
  output logic                            rdy_o,
  output logic [data_width-1:0]           data_o,
  output logic [NumSlaves-1:0]            slave_sel_o,
  input  logic [NumSlaves*data_width-1:0] slave_data_i
);

  localparam int unsigned IdxWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  logic [NumSlaves-1:0] dec_sel;
  logic                 dec_hit;
  logic [IdxWidth-1:0]  dec_idx;

  cpu_bus_decoder #(
    .address_width(address_width),
    .NumSlaves    (NumSlaves),
    .IdxWidth     (IdxWidth),
    .SlaveMap     (SlaveMap)
  ) u_decoder (
    .address_i(address_i),
    .sel_o    (dec_sel),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx)
  );

  logic [address_width-1:0] stat_rel;
  logic                     status_hit;
  logic [1:0]               stat_off;

  assign stat_rel    = address_i - StatusBaseAddress;
  assign status_hit  = (address_i >= StatusBaseAddress) && (stat_rel < address_width'(4));
  assign stat_off    = stat_rel[1:0];
  assign slave_sel_o = status_hit ? '0 : dec_sel;

  latency_t lat_tab [NumSlaves];
  latency_t lat_sel;

  for (genvar g = 0; g < NumSlaves; g++) begin : g_lat
    assign lat_tab[g] = SlaveLatency[2*(NumSlaves-1-g) +: 2];
  end

  always_comb begin
    lat_sel = latency_t'(1);
    for (int unsigned i = 0; i < NumSlaves; i++) begin
      if (IdxWidth'(i) == dec_idx) lat_sel = lat_tab[i];
    end
    if (lat_sel == 2'd0) lat_sel = latency_t'(1);
  end

  state_t                   state_q, state_d;
  latency_t                 cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic [data_width-1:0]    hold_q;
  access_t                  kind_q;
  logic [IdxWidth-1:0]      idx_q;
  logic [address_width-1:0] addr_q;

  logic accept, rd_accept, unmapped, stat_wr;

  assign rdy_o     = (state_q == IDLE);
  assign accept    = rdy_o;
  assign rd_accept = accept && !rd_wr_i;
  assign unmapped  = accept && !status_hit && !dec_hit;
  assign stat_wr   = accept && rd_wr_i && status_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_accept && !status_hit && dec_hit && lat_sel >= 2'd2) begin
          state_d = WAIT;
          cnt_d   = latency_t'(lat_sel - 2'd2);
        end else if (rd_accept) begin
          valid_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      kind_q  <= ACC_NONE;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hold_q  <= data_o;
      if (rd_accept) begin
        kind_q <= status_hit ? ACC_STATUS : (dec_hit ? ACC_SLAVE : ACC_NONE);
        idx_q  <= dec_idx;
        addr_q <= address_i;
      end
    end
  end

  logic [1:0]  flags_q, flags_d;
  logic [15:0] last_q;
  logic [7:0]  count_q, count_d;

  // Clears are applied first so that a simultaneous set/increment takes precedence.
  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    if (stat_wr && stat_off == StatusFlags) flags_d = flags_q & ~data_i[1:0];
    if (stat_wr && stat_off == StatusCount) count_d = '0;
    if (unmapped) begin
      if (rd_wr_i) flags_d[1] = 1'b1;
      else         flags_d[0] = 1'b1;
      count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_q <= '0;
      last_q  <= '0;
      count_q <= '0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      if (unmapped) last_q <= 16'(address_i);
    end
  end

  logic [address_width-1:0] rd_rel;
  logic [data_width-1:0]    stat_byte, slave_byte, mux_byte;

  assign rd_rel = addr_q - StatusBaseAddress;

  always_comb begin
    case (rd_rel[1:0])
      StatusFlags:  stat_byte = data_width'(flags_q);
      StatusAddrLo: stat_byte = data_width'(last_q[7:0]);
      StatusAddrHi: stat_byte = data_width'(last_q[15:8]);
      default:      stat_byte = data_width'(count_q);
    endcase
  end

  always_comb begin
    slave_byte = '0;
    for (int unsigned i = 0; i < NumSlaves; i++) begin
      if (IdxWidth'(i) == idx_q)
        slave_byte = slave_data_i[(NumSlaves-1-i)*data_width +: data_width];
    end
  end

  always_comb begin
    case (kind_q)
      ACC_SLAVE:  mux_byte = slave_byte;
      ACC_STATUS: mux_byte = stat_byte;
      default:    mux_byte = DefaultData;
    endcase
  end

  assign data_o = valid_q ? mux_byte : hold_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Directed bench for cpu_bus_fabric: 4 slaves with latencies 0(->1),2,1,3,
// overlapping slaves 1/2, and the unmapped-access status block.
module tb_cpu_bus_fabric;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        rd_wr_i;
  logic        rdy_o;
  logic [7:0]  data_o;
  logic [3:0]  slave_sel_o;
  logic [31:0] slave_data_i;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] Map = {16'h0000, 16'h2FFF,
                                  16'h9000, 16'h91FF,
                                  16'h9100, 16'h93FF,
                                  16'hA000, 16'hBFFF};
  localparam logic [7:0] Lat = 8'b00_10_01_11;

  cpu_bus_fabric #(
    .address_width    (16),
    .data_width       (8),
    .NumSlaves        (4),
    .SlaveMap         (Map),
    .SlaveLatency     (Lat),
    .StatusBaseAddress(16'h9FF0),
    .DefaultData      (8'hEA)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .address_i   (address_i),
    .data_i      (data_i),
    .rd_wr_i     (rd_wr_i),
    .rdy_o       (rdy_o),
    .data_o      (data_o),
    .slave_sel_o (slave_sel_o),
    .slave_data_i(slave_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    @(posedge clk_i);
    #1;
    address_i = a;
    data_i    = d;
    rd_wr_i   = w;
    reset_i   = r;
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    slave_data_i = {8'hA9, 8'h11, 8'h22, 8'h33};
    address_i = '0; data_i = '0; rd_wr_i = 1'b1; reset_i = 1'b1;
    step(16'h0000, 8'h00, 1'b1, 1'b1);
    step(16'h0000, 8'h00, 1'b1, 1'b1);

    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("reset_rdy", rdy_o, 1'b1);
    check("reset_data", data_o, 8'h00);
    check("sel_0000", slave_sel_o, 4'b0001);

    step(16'h0200, 8'h00, 1'b0, 1'b0);
    check("l1_rdy_T", rdy_o, 1'b1);
    check("sel_0200", slave_sel_o, 4'b0001);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("l1_rdy_T1", rdy_o, 1'b1);
    check("l1_data", data_o, 8'hA9);

    step(16'hA010, 8'h00, 1'b0, 1'b0);
    check("sel_a010", slave_sel_o, 4'b1000);
    step(16'hA010, 8'h00, 1'b0, 1'b0);
    check("l3_rdy_T1", rdy_o, 1'b0);
    check("l3_hold_T1", data_o, 8'hA9);
    step(16'hA010, 8'h00, 1'b0, 1'b0);
    check("l3_rdy_T2", rdy_o, 1'b0);
    check("l3_sel_wait", slave_sel_o, 4'b1000);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("l3_rdy_T3", rdy_o, 1'b1);
    check("l3_data", data_o, 8'h33);

    step(16'h9100, 8'h00, 1'b0, 1'b0);
    check("overlap_sel", slave_sel_o, 4'b0010);
    step(16'h9100, 8'h00, 1'b0, 1'b0);
    check("l2_rdy_T1", rdy_o, 1'b0);
    step(16'h9200, 8'h00, 1'b0, 1'b0);
    check("l2_rdy_T2", rdy_o, 1'b1);
    check("overlap_data", data_o, 8'h11);
    check("sel_9200", slave_sel_o, 4'b0100);

    step(16'h7000, 8'h55, 1'b1, 1'b0);
    check("s2_data", data_o, 8'h22);
    check("unmapped_sel", slave_sel_o, 4'b0000);
    check("unmapped_wr_rdy", rdy_o, 1'b1);
    step(16'h9FF0, 8'h00, 1'b0, 1'b0);
    check("status_sel", slave_sel_o, 4'b0000);
    step(16'h9FF1, 8'h00, 1'b0, 1'b0);
    check("flags_wr", data_o, 8'h02);
    step(16'h9FF2, 8'h00, 1'b0, 1'b0);
    check("last_lo", data_o, 8'h00);
    step(16'h9FF3, 8'h00, 1'b0, 1'b0);
    check("last_hi", data_o, 8'h70);
    step(16'h7000, 8'h00, 1'b0, 1'b0);
    check("count_1", data_o, 8'h01);
    step(16'h9FF0, 8'h00, 1'b0, 1'b0);
    check("default_data", data_o, 8'hEA);
    step(16'h9FF3, 8'h00, 1'b0, 1'b0);
    check("flags_rw", data_o, 8'h03);
    step(16'h3000, 8'h00, 1'b0, 1'b0);
    check("count_2", data_o, 8'h02);
    check("sel_3000", slave_sel_o, 4'b0000);
    step(16'h9FF3, 8'h00, 1'b0, 1'b0);
    check("default_3000", data_o, 8'hEA);
    step(16'h9FF2, 8'h00, 1'b0, 1'b0);
    check("count_3", data_o, 8'h03);
    step(16'h2FFF, 8'h00, 1'b0, 1'b0);
    check("last_hi_3000", data_o, 8'h30);
    check("sel_2fff", slave_sel_o, 4'b0001);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("data_2fff", data_o, 8'hA9);

    for (int i = 0; i < 300; i++) step(16'h8012, 8'h00, 1'b1, 1'b0);
    step(16'h9FF3, 8'h00, 1'b0, 1'b0);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("count_sat", data_o, 8'hFF);

    step(16'h9FF0, 8'h01, 1'b1, 1'b0);
    step(16'h9FF0, 8'h00, 1'b0, 1'b0);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("w1c_b0", data_o, 8'h02);
    step(16'h8012, 8'h00, 1'b0, 1'b0);
    step(16'h9FF0, 8'h00, 1'b0, 1'b0);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("b0_reset", data_o, 8'h03);

    step(16'h9FF3, 8'h00, 1'b1, 1'b0);
    step(16'h9FF3, 8'h00, 1'b0, 1'b0);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("count_clr", data_o, 8'h00);
    step(16'h9FF1, 8'hAA, 1'b1, 1'b0);
    step(16'h9FF1, 8'h00, 1'b0, 1'b0);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("lo_readonly", data_o, 8'h12);

    step(16'hA010, 8'h00, 1'b0, 1'b0);
    step(16'hA010, 8'h00, 1'b0, 1'b0);
    check("rst_wait_rdy", rdy_o, 1'b0);
    check("rst_wait_hold", data_o, 8'h12);
    step(16'hA010, 8'h00, 1'b0, 1'b1);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("rst_abort_rdy", rdy_o, 1'b1);
    check("rst_abort_data", data_o, 8'h00);
    step(16'h9FF0, 8'h00, 1'b0, 1'b0);
    step(16'h9FF3, 8'h00, 1'b0, 1'b0);
    check("rst_flags", data_o, 8'h00);
    step(16'h9FF1, 8'h00, 1'b0, 1'b0);
    check("rst_count", data_o, 8'h00);
    step(16'h0000, 8'h00, 1'b1, 1'b0);
    check("rst_last_lo", data_o, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
